fetch_prefetch: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue. Owns the fetch PC, issues

---
 rtl/fetch_prefetch_pkg.sv | 17 +
 rtl/fetch_prefetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_prefetch.sv | 84 ++++++++
 tb/tb_fetch_prefetch.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: default encodings and sizing shared by the fetch stage files.
// Latency: n/a (constants and a pure sizing function only).
// Backpressure: n/a.
package fetch_prefetch_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_FQ_DEPTH = 4;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // addi x0,x0,0 -- presented to decode while nothing is queued
  localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: decode/redirect handshake plus instruction-memory port of the fetch stage.
// Latency: n/a (wires only).
// Backpressure: stall from decode; memory has none (fixed 1-cycle read).
interface fetch_prefetch_if
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned FQ_DEPTH = DEF_FQ_DEPTH
);
  logic                               stall;
  logic                               wb;
  logic [XLEN-1:0]                    pc_addr;
  logic                               imem_req;
  logic [XLEN-1:0]                    imem_addr;
  logic [XLEN-1:0]                    imem_rdata;
  logic                               ir_valid;
  logic [XLEN-1:0]                    pc_out;
  logic [XLEN-1:0]                    ir_out;
  logic [cnt_w(FQ_DEPTH)-1:0]         fq_count;

  modport master (
    input  stall, wb, pc_addr, imem_rdata,
    output imem_req, imem_addr, ir_valid, pc_out, ir_out, fq_count
  );

  modport slave (
    output stall, wb, pc_addr, imem_rdata,
    input  imem_req, imem_addr, ir_valid, pc_out, ir_out, fq_count
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO, power-of-two DEPTH, flush clears pointers and count.
// Latency: push visible at head the cycle after the write edge (no bypass).
// Backpressure: push when full and pop when empty are ignored; caller owns credit.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & (count != CW'(DEPTH));
  assign do_pop   = pop & (count != '0);
  assign head_dat = mem[rptr];

  // Pointers wrap naturally; occupancy lives in count, so full/empty never alias.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: owns the fetch PC, issues sequential imem reads, queues {pc,ir} for decode.
// Latency: 2 cycles from imem_req to ir_valid; sustains 1 instr/cycle with stall=0.
// Backpressure: stall holds the head; issue stops once queued + in-flight uses every slot.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = DEF_XLEN,
  parameter int unsigned     FQ_DEPTH = DEF_FQ_DEPTH,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(DEF_PC_STEP),
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(DEF_NOP_INSN)
) (
  input logic              clk,
  input logic              rst,
  fetch_prefetch_if.master bus
);
  localparam int unsigned CW = cnt_w(FQ_DEPTH);
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q;
  logic            inflight;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW-1:0]   count;
  logic [OW-1:0]   credit_use;
  entry_t          push_dat;
  entry_t          head_dat;

  assign bus.ir_valid = (count != '0);
  assign pop          = bus.ir_valid & ~bus.stall;

  // A slot is reserved at issue time, so the response push can never overflow.
  assign credit_use = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue      = ~rst & ~bus.wb & (credit_use < OW'(FQ_DEPTH));

  // Response landing in a redirect cycle belongs to the old path and is dropped.
  assign push     = inflight & ~bus.wb;
  assign push_dat = '{pc: pc_q, ir: bus.imem_rdata};

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop & ~bus.wb),
    .flush    (bus.wb),
    .head_dat (head_dat),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
    end else if (bus.wb) begin
      fetch_pc <= bus.pc_addr;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
        pc_q     <= fetch_pc;
      end
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.fq_count  = count;
  assign bus.pc_out    = bus.ir_valid ? head_dat.pc : '0;
  assign bus.ir_out    = bus.ir_valid ? head_dat.ir : NOP_INSN;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed table, corner sequences and random traffic vs a queue-level model.
// Memory model answers every request with addr>>2 one cycle later.
module tb_fetch_prefetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.XLEN(32), .FQ_DEPTH(4)) bus ();

  fetch_prefetch #(
    .XLEN     (32),
    .FQ_DEPTH (4),
    .PC_STEP  (32'd4),
    .RESET_PC (32'h0),
    .NOP_INSN (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) if (bus.imem_req === 1'b1) bus.imem_rdata <= bus.imem_addr >> 2;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: a queue of fetched instructions plus at most one outstanding read.
  typedef struct {logic [31:0] pc; logic [31:0] ir;} ent_t;
  ent_t        mq[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_fetch;

  logic        a_req, a_valid, e_req, e_valid;
  logic [31:0] a_addr, a_pc, a_ir, e_addr, e_pc, e_ir;
  logic [2:0]  a_cnt, e_cnt;

  task automatic step(input logic r, input logic w, input logic [31:0] pa, input logic s);
    logic pop;
    @(negedge clk);
    rst = r; bus.wb = w; bus.pc_addr = pa; bus.stall = s;
    #1;
    a_req = bus.imem_req; a_addr = bus.imem_addr; a_valid = bus.ir_valid;
    a_pc = bus.pc_out; a_ir = bus.ir_out; a_cnt = bus.fq_count;
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_ir    = e_valid ? mq[0].ir : NOP;
    e_cnt   = 3'(mq.size());
    pop     = e_valid && !s;
    e_req   = !r && !w && ((mq.size() + (m_pend ? 1 : 0) - (pop ? 1 : 0)) < 4);
    e_addr  = m_fetch;
    if (r) begin
      mq.delete(); m_pend = 1'b0; m_fetch = 32'h0;
    end else if (w) begin
      mq.delete(); m_pend = 1'b0; m_fetch = pa;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back('{pc: m_pend_pc, ir: m_pend_pc >> 2});
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic r, w, s; logic [31:0] pa;
    logic x_req; logic [31:0] x_addr; logic x_valid; logic [31:0] x_pc, x_ir; logic [2:0] x_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, w, s, input logic [31:0] pa, input logic xq,
                              input logic [31:0] xa, input logic xv, input logic [31:0] xp,
                              input logic [31:0] xi, input logic [2:0] xc);
    vec_t v;
    v.r = r; v.w = w; v.s = s; v.pa = pa; v.x_req = xq; v.x_addr = xa;
    v.x_valid = xv; v.x_pc = xp; v.x_ir = xi; v.x_cnt = xc;
    return v;
  endfunction

  vec_t tv[22];

  initial begin
    logic r, w, s;
    logic [31:0] pa;
    rst = 1'b1; bus.wb = 1'b0; bus.pc_addr = 32'h0; bus.stall = 1'b0;
    m_pend = 1'b0; m_pend_pc = 32'h0; m_fetch = 32'h0;

    //          r  w  s  pa          req addr          vld pc            ir            cnt
    tv[0]  = mk(1, 0, 0, 32'h0,      0, 32'h0,          0, 32'h0,        NOP,          0);
    tv[1]  = mk(0, 0, 0, 32'h0,      1, 32'h0,          0, 32'h0,        NOP,          0);
    tv[2]  = mk(0, 0, 0, 32'h0,      1, 32'h4,          0, 32'h0,        NOP,          0);
    tv[3]  = mk(0, 0, 0, 32'h0,      1, 32'h8,          1, 32'h0,        32'h0,        1);
    tv[4]  = mk(0, 0, 0, 32'h0,      1, 32'hC,          1, 32'h4,        32'h1,        1);
    tv[5]  = mk(0, 0, 0, 32'h0,      1, 32'h10,         1, 32'h8,        32'h2,        1);
    tv[6]  = mk(0, 0, 1, 32'h0,      1, 32'h14,         1, 32'hC,        32'h3,        1);
    tv[7]  = mk(0, 0, 1, 32'h0,      1, 32'h18,         1, 32'hC,        32'h3,        2);
    tv[8]  = mk(0, 0, 1, 32'h0,      0, 32'h0,          1, 32'hC,        32'h3,        3);
    tv[9]  = mk(0, 0, 1, 32'h0,      0, 32'h0,          1, 32'hC,        32'h3,        4);
    tv[10] = mk(0, 0, 1, 32'h0,      0, 32'h0,          1, 32'hC,        32'h3,        4);
    tv[11] = mk(0, 0, 0, 32'h0,      1, 32'h1C,         1, 32'hC,        32'h3,        4);
    tv[12] = mk(0, 0, 0, 32'h0,      1, 32'h20,         1, 32'h10,       32'h4,        3);
    tv[13] = mk(0, 1, 0, 32'h100,    0, 32'h0,          1, 32'h14,       32'h5,        3);
    tv[14] = mk(0, 0, 0, 32'h0,      1, 32'h100,        0, 32'h0,        NOP,          0);
    tv[15] = mk(0, 0, 0, 32'h0,      1, 32'h104,        0, 32'h0,        NOP,          0);
    tv[16] = mk(0, 0, 0, 32'h0,      1, 32'h108,        1, 32'h100,      32'h40,       1);
    tv[17] = mk(0, 1, 0, 32'h200,    0, 32'h0,          1, 32'h104,      32'h41,       1);
    tv[18] = mk(0, 1, 0, 32'h300,    0, 32'h0,          0, 32'h0,        NOP,          0);
    tv[19] = mk(0, 0, 0, 32'h0,      1, 32'h300,        0, 32'h0,        NOP,          0);
    tv[20] = mk(0, 0, 0, 32'h0,      1, 32'h304,        0, 32'h0,        NOP,          0);
    tv[21] = mk(0, 0, 0, 32'h0,      1, 32'h308,        1, 32'h300,      32'hC0,       1);

    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      step(tv[i].r, tv[i].w, tv[i].pa, tv[i].s);
      chk($sformatf("tv%0d_req", i), 32'(a_req), 32'(tv[i].x_req));
      if (tv[i].x_req) chk($sformatf("tv%0d_addr", i), a_addr, tv[i].x_addr);
      chk($sformatf("tv%0d_valid", i), 32'(a_valid), 32'(tv[i].x_valid));
      chk($sformatf("tv%0d_cnt", i), 32'(a_cnt), 32'(tv[i].x_cnt));
      chk($sformatf("tv%0d_pc", i), a_pc, tv[i].x_pc);
      chk($sformatf("tv%0d_ir", i), a_ir, tv[i].x_ir);
    end

    // Reset with every credit in use (3 queued + 1 in flight).
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_cnt_before", 32'(a_cnt), 32'd3);
    chk("rst_req_in_rst", 32'(a_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_valid_after", 32'(a_valid), 32'd0);
    chk("rst_cnt_after", 32'(a_cnt), 32'd0);
    chk("rst_first_req", 32'(a_req), 32'd1);
    chk("rst_first_addr", a_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_no_stale", 32'(a_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_head_pc", a_pc, 32'h0);
    chk("rst_head_ir", a_ir, 32'h0);

    // PC wrap past 2^32.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    chk("wrap_wb_req", 32'(a_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr0", a_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr1", a_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr2", a_addr, 32'h0);
    chk("wrap_pc0", a_pc, 32'hFFFF_FFF8);
    chk("wrap_ir0", a_ir, 32'h3FFF_FFFE);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr3", a_addr, 32'h4);
    chk("wrap_pc1", a_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc2", a_pc, 32'h0);
    chk("wrap_ir2", a_ir, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      w  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 4) < 2);
      pa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'hFFFF_FFFC);
      step(r, w, pa, s);
      chk("rnd_req", 32'(a_req), 32'(e_req));
      if (e_req) chk("rnd_addr", a_addr, e_addr);
      chk("rnd_valid", 32'(a_valid), 32'(e_valid));
      chk("rnd_cnt", 32'(a_cnt), 32'(e_cnt));
      chk("rnd_pc", a_pc, e_pc);
      chk("rnd_ir", a_ir, e_ir);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
